layer_colorizer: RTL and testbench
==================================

LAYER_COLORIZER -- requirements
Module: layer_colorizer

Interface
REQ-001 Parameter NUM_LAYERS, default 4, count of icon layers composited; legal range 1..8.
REQ-002 Parameter COLOR_W, default 4, bits per colour channel; legal range 4..8.
REQ-003 Localparam PIX_W = 3*COLOR_W; localparam FADE_MAX = 2**COLOR_W; localparam LVL_W = COLOR_W+1.
REQ-004 pClk  input  1  single clock; all logic on rising edge.
REQ-005 pReset  input  1  synchronous, active-high reset.
REQ-006 pLayerPix  input  NUM_LAYERS*PIX_W  layer k pixel at bits [k*PIX_W +: PIX_W], packed {R,G,B}.
REQ-007 pLayerOpaque  input  NUM_LAYERS  bit k high = layer k pixel visible; low = transparent.
REQ-008 pBackground  input  PIX_W  colour used when no layer is opaque.
REQ-009 pVideo_on  input  1  active-display flag from DTG, aligned with pixel inputs.
REQ-010 pFrameStart  input  1  one-cycle pulse per frame; fade step tick.
REQ-011 pFadeCmd  input  2  00 hold, 01 fade-in, 10 fade-out, 11 snap-to-full.
REQ-012 pFadeGo  input  1  one-cycle pulse; samples pFadeCmd.
REQ-013 pRed_VGA / pGreen_VGA / pBlue_VGA  output  COLOR_W each  registered colour outputs.
REQ-014 pVideo_on_out  output  1  pVideo_on delayed to align with colour outputs.
REQ-015 pFadeBusy  output  1  high while FSM in FADE_IN or FADE_OUT.
REQ-016 pFadeLevel  output  LVL_W  current brightness level, 0..FADE_MAX.

Function
REQ-017 Stage 1 (register): select lowest-index k with pLayerOpaque[k]=1; else pBackground; if pVideo_on=0, select zero.
REQ-018 Stage 2 (register): each channel out = (c * level) >> COLOR_W, full-width product, truncation not rounding; level = pFadeLevel value sampled in stage 2's cycle.
REQ-019 Latency fixed 2 cycles input-to-output, pipeline never stalls; pVideo_on_out = pVideo_on delayed 2 cycles.
REQ-020 When pVideo_on_out=0 all colour outputs shall be 0 regardless of level.
REQ-021 Level FADE_MAX shall pass colour unchanged; level 0 shall produce black.
REQ-022 Fade FSM states IDLE, FADE_IN, FADE_OUT.
REQ-023 pFadeGo with cmd 01 -> FADE_IN; cmd 10 -> FADE_OUT; cmd 11 -> level=FADE_MAX next cycle, IDLE; cmd 00 -> IDLE, level held. Accepted from any state, including mid-fade (reverses from current level).
REQ-024 FADE_IN: on each pFrameStart level += 1; on reaching FADE_MAX -> IDLE. FADE_OUT: level -= 1; on reaching 0 -> IDLE.
REQ-025 Fade-in commanded at FADE_MAX, or fade-out at 0: FSM enters state then returns to IDLE on next pFrameStart with level unchanged; no wrap-around ever.
REQ-026 pFadeGo and pFrameStart same cycle: command takes effect, no step that cycle; first step on next pFrameStart.
REQ-027 pFrameStart in IDLE has no effect.

Reset
REQ-028 On pReset: colour outputs 0, pVideo_on_out 0, both pipeline stages cleared, FSM IDLE, pFadeLevel FADE_MAX, pFadeBusy 0.
REQ-029 Reset mid-fade abandons fade; first valid output 2 cycles after pReset deasserts.

Structure
REQ-030 Fade state encoding and pFadeCmd codes shall live in shared package colorizer_pkg.
REQ-031 Fade FSM plus level counter shall be sub-module fade_ctrl; compositing and scaling stay in layer_colorizer.

Verification
REQ-032 Defaults, layer0 opaque 0xF00, layer2 opaque 0x0F0, video on -> output 0xF00 two cycles later; layer0 transparent -> 0x0F0.
REQ-033 No layer opaque, pBackground 0x123, video on -> 0x123; pVideo_on low -> 0x000 and pVideo_on_out low after 2 cycles.
REQ-034 Fade-out from 16 with 16 pFrameStart pulses -> level 15..0, pFadeBusy drops after level 0; pixel 0xFFF at level 8 -> 0x777.
REQ-035 Fade-out to level 5, then pFadeGo cmd 01 same cycle as pFrameStart -> level stays 5 that cycle, then 6 on next pulse.
REQ-036 Fade-in at level 16 -> level stays 16, busy low after next pFrameStart; cmd 11 at level 3 -> level 16 next cycle.
REQ-037 pReset asserted at level 7 during FADE_OUT -> level 16, IDLE, outputs 0 next cycle.

Source files
------------

// File: rtl/colorizer_pkg.sv
// Shared fade-controller types: FSM state encoding and the pFadeCmd command codes.
package colorizer_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StFadeIn  = 2'd1,
        StFadeOut = 2'd2
    } fadeState_t;

    typedef enum logic [1:0] {
        CmdHold    = 2'b00,
        CmdFadeIn  = 2'b01,
        CmdFadeOut = 2'b10,
        CmdSnap    = 2'b11
    } fadeCmd_t;

endpackage

// File: rtl/layer_colorizer_if.sv
// Pixel bus between the layer sources / DTG and the colorizer, plus the VGA colour outputs.
interface layer_colorizer_if #(
    parameter int NUM_LAYERS = 4,
    parameter int COLOR_W    = 4
);
    localparam int PIX_W = 3 * COLOR_W;

    logic [NUM_LAYERS*PIX_W-1:0] pLayerPix;
    logic [NUM_LAYERS-1:0]       pLayerOpaque;
    logic [PIX_W-1:0]            pBackground;
    logic                        pVideo_on;
    logic [COLOR_W-1:0]          pRed_VGA;
    logic [COLOR_W-1:0]          pGreen_VGA;
    logic [COLOR_W-1:0]          pBlue_VGA;
    logic                        pVideo_on_out;

    modport master (
        output pLayerPix, pLayerOpaque, pBackground, pVideo_on,
        input  pRed_VGA, pGreen_VGA, pBlue_VGA, pVideo_on_out
    );

    modport slave (
        input  pLayerPix, pLayerOpaque, pBackground, pVideo_on,
        output pRed_VGA, pGreen_VGA, pBlue_VGA, pVideo_on_out
    );

endinterface

// File: rtl/fade_ctrl.sv
// Fade FSM and brightness level counter; steps once per frame, saturates at 0 and FADE_MAX.
module fade_ctrl
    import colorizer_pkg::*;
#(
    parameter int COLOR_W = 4
) (
    input  logic               pClk,
    input  logic               pReset,
    input  logic               pFrameStart,
    input  logic [1:0]         pFadeCmd,
    input  logic               pFadeGo,
    output logic               pFadeBusy,
    output logic [COLOR_W:0]   pFadeLevel
);
    localparam int FADE_MAX = 2 ** COLOR_W;
    localparam int LVL_W    = COLOR_W + 1;
    localparam logic [LVL_W-1:0] LvlMax = LVL_W'(FADE_MAX);
    localparam logic [LVL_W-1:0] LvlOne = LVL_W'(1);

    fadeState_t fadeState;

    // A command wins over a frame tick in the same cycle; stepping resumes on the next tick.
    always_ff @(posedge pClk) begin
        if (pReset) begin
            fadeState  <= StIdle;
            pFadeLevel <= LvlMax;
            pFadeBusy  <= 1'b0;
        end else if (pFadeGo) begin
            unique case (fadeCmd_t'(pFadeCmd))
                CmdHold: begin
                    fadeState <= StIdle;
                    pFadeBusy <= 1'b0;
                end
                CmdFadeIn: begin
                    fadeState <= StFadeIn;
                    pFadeBusy <= 1'b1;
                end
                CmdFadeOut: begin
                    fadeState <= StFadeOut;
                    pFadeBusy <= 1'b1;
                end
                CmdSnap: begin
                    fadeState  <= StIdle;
                    pFadeLevel <= LvlMax;
                    pFadeBusy  <= 1'b0;
                end
            endcase
        end else if (pFrameStart) begin
            case (fadeState)
                StFadeIn: begin
                    if (pFadeLevel != LvlMax) pFadeLevel <= pFadeLevel + LvlOne;
                    if (pFadeLevel >= LvlMax - LvlOne) begin
                        fadeState <= StIdle;
                        pFadeBusy <= 1'b0;
                    end
                end
                StFadeOut: begin
                    if (pFadeLevel != '0) pFadeLevel <= pFadeLevel - LvlOne;
                    if (pFadeLevel <= LvlOne) begin
                        fadeState <= StIdle;
                        pFadeBusy <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/layer_colorizer.sv
// Two-stage pixel pipeline: priority layer select, then per-channel brightness scaling.
module layer_colorizer
    import colorizer_pkg::*;
#(
    parameter int NUM_LAYERS = 4,
    parameter int COLOR_W    = 4
) (
    input  logic             pClk,
    input  logic             pReset,
    layer_colorizer_if.slave vid,
    input  logic             pFrameStart,
    input  logic [1:0]       pFadeCmd,
    input  logic             pFadeGo,
    output logic             pFadeBusy,
    output logic [COLOR_W:0] pFadeLevel
);
    localparam int PIX_W = 3 * COLOR_W;
    localparam int LVL_W = COLOR_W + 1;

    logic [PIX_W-1:0]   pixSel;
    logic [PIX_W-1:0]   s1Pix;
    logic               s1Vid;
    logic [COLOR_W-1:0] redQ, greenQ, blueQ;
    logic               vidQ;

    fade_ctrl #(
        .COLOR_W(COLOR_W)
    ) uFadeCtrl (
        .pClk       (pClk),
        .pReset     (pReset),
        .pFrameStart(pFrameStart),
        .pFadeCmd   (pFadeCmd),
        .pFadeGo    (pFadeGo),
        .pFadeBusy  (pFadeBusy),
        .pFadeLevel (pFadeLevel)
    );

    // Full-width product then drop COLOR_W LSBs; level FADE_MAX is an exact pass-through.
    function automatic logic [COLOR_W-1:0] scaleChan(input logic [COLOR_W-1:0] c,
                                                     input logic [LVL_W-1:0]   lvl);
        logic [2*COLOR_W-1:0] prod;
        prod = (2*COLOR_W)'(c) * (2*COLOR_W)'(lvl);
        return COLOR_W'(prod >> COLOR_W);
    endfunction

    // Descending scan so the lowest opaque index ends up selected.
    always_comb begin
        pixSel = vid.pBackground;
        for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
            if (vid.pLayerOpaque[k]) pixSel = vid.pLayerPix[k*PIX_W +: PIX_W];
        end
        if (!vid.pVideo_on) pixSel = '0;
    end

    always_ff @(posedge pClk) begin
        if (pReset) begin
            s1Pix  <= '0;
            s1Vid  <= 1'b0;
            redQ   <= '0;
            greenQ <= '0;
            blueQ  <= '0;
            vidQ   <= 1'b0;
        end else begin
            s1Pix <= pixSel;
            s1Vid <= vid.pVideo_on;
            vidQ  <= s1Vid;
            if (s1Vid) begin
                redQ   <= scaleChan(s1Pix[2*COLOR_W +: COLOR_W], pFadeLevel);
                greenQ <= scaleChan(s1Pix[COLOR_W +: COLOR_W], pFadeLevel);
                blueQ  <= scaleChan(s1Pix[0 +: COLOR_W], pFadeLevel);
            end else begin
                redQ   <= '0;
                greenQ <= '0;
                blueQ  <= '0;
            end
        end
    end

    assign vid.pRed_VGA      = redQ;
    assign vid.pGreen_VGA    = greenQ;
    assign vid.pBlue_VGA     = blueQ;
    assign vid.pVideo_on_out = vidQ;

endmodule

// File: tb/tb_layer_colorizer.sv
// Directed bench for layer_colorizer: behavioural model checked every cycle plus literal pins.
module tb_layer_colorizer;
    localparam int NUM_LAYERS = 4;
    localparam int COLOR_W    = 4;
    localparam int FADE_MAX   = 16;

    logic       pClk = 1'b0;
    logic       pReset = 1'b1;
    logic       pFrameStart = 1'b0;
    logic       pFadeGo = 1'b0;
    logic [1:0] pFadeCmd = 2'b00;
    logic       pFadeBusy;
    logic [4:0] pFadeLevel;

    layer_colorizer_if #(.NUM_LAYERS(NUM_LAYERS), .COLOR_W(COLOR_W)) vif ();

    layer_colorizer #(
        .NUM_LAYERS(NUM_LAYERS),
        .COLOR_W   (COLOR_W)
    ) dut (
        .pClk       (pClk),
        .pReset     (pReset),
        .vid        (vif),
        .pFrameStart(pFrameStart),
        .pFadeCmd   (pFadeCmd),
        .pFadeGo    (pFadeGo),
        .pFadeBusy  (pFadeBusy),
        .pFadeLevel (pFadeLevel)
    );

    always #5 pClk = ~pClk;

    int nVec = 0;
    int nErr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---- behavioural model ----
    int         mLevel = FADE_MAX;
    int         mDir = 0;            // 0 still, +1 brightening, -1 dimming
    logic [11:0] mStage = '0;
    logic        mStageVid = 1'b0;
    logic [11:0] expPix = '0;
    logic        expVid = 1'b0;
    bit          started = 0;

    function automatic logic [11:0] pickPixel();
        for (int k = 0; k < NUM_LAYERS; k++)
            if (vif.pLayerOpaque[k]) return vif.pLayerPix[k*12 +: 12];
        return vif.pBackground;
    endfunction

    function automatic logic [11:0] dim(input logic [11:0] p, input int lvl);
        int r, g, b;
        r = int'(p[11:8]) * lvl / FADE_MAX;
        g = int'(p[7:4]) * lvl / FADE_MAX;
        b = int'(p[3:0]) * lvl / FADE_MAX;
        return {r[3:0], g[3:0], b[3:0]};
    endfunction

    always @(posedge pClk) begin
        if (pReset) begin
            expPix = '0; expVid = 1'b0; mStage = '0; mStageVid = 1'b0;
            mLevel = FADE_MAX; mDir = 0;
        end else begin
            expVid = mStageVid;
            expPix = mStageVid ? dim(mStage, mLevel) : 12'h000;
            mStage = vif.pVideo_on ? pickPixel() : 12'h000;
            mStageVid = vif.pVideo_on;
            if (pFadeGo) begin
                case (pFadeCmd)
                    2'b00: mDir = 0;
                    2'b01: mDir = 1;
                    2'b10: mDir = -1;
                    default: begin mLevel = FADE_MAX; mDir = 0; end
                endcase
            end else if (pFrameStart && mDir != 0) begin
                mLevel = mLevel + mDir;
                if (mLevel > FADE_MAX) mLevel = FADE_MAX;
                if (mLevel < 0) mLevel = 0;
                if (mLevel == FADE_MAX || mLevel == 0) mDir = 0;
            end
        end
        started = 1;
    end

    always @(negedge pClk) begin
        if (started) begin
            check("model_red", 32'(vif.pRed_VGA), 32'(expPix[11:8]));
            check("model_green", 32'(vif.pGreen_VGA), 32'(expPix[7:4]));
            check("model_blue", 32'(vif.pBlue_VGA), 32'(expPix[3:0]));
            check("model_vid", 32'(vif.pVideo_on_out), 32'(expVid));
            check("model_level", 32'(pFadeLevel), 32'(mLevel));
            check("model_busy", 32'(pFadeBusy), 32'(mDir != 0));
        end
    end

    // ---- directed stimulus with literal expectations ----
    task automatic cyc(input int n);
        repeat (n) @(negedge pClk);
    endtask

    task automatic step();
        pFrameStart = 1'b1;
        cyc(1);
        pFrameStart = 1'b0;
    endtask

    task automatic go(input logic [1:0] cmd, input bit withFrame);
        pFadeGo = 1'b1;
        pFadeCmd = cmd;
        pFrameStart = withFrame;
        cyc(1);
        pFadeGo = 1'b0;
        pFrameStart = 1'b0;
    endtask

    task automatic expectOut(input string name, input logic [11:0] rgb, input logic v);
        check(name, 32'({vif.pRed_VGA, vif.pGreen_VGA, vif.pBlue_VGA}), 32'(rgb));
        check({name, "_vid"}, 32'(vif.pVideo_on_out), 32'(v));
    endtask

    task automatic expectFade(input string name, input int lvl, input bit busy);
        check({name, "_level"}, 32'(pFadeLevel), 32'(lvl));
        check({name, "_busy"}, 32'(pFadeBusy), 32'(busy));
    endtask

    initial begin
        vif.pLayerPix    = '0;
        vif.pLayerOpaque = '0;
        vif.pBackground  = '0;
        vif.pVideo_on    = 1'b0;
        cyc(2);
        expectOut("reset_out", 12'h000, 1'b0);
        expectFade("reset", 16, 1'b0);
        pReset = 1'b0;

        // Priority: layer 0 over layer 2, then layer 2 alone
        vif.pLayerPix    = {12'h000, 12'h0F0, 12'h000, 12'hF00};
        vif.pLayerOpaque = 4'b0101;
        vif.pVideo_on    = 1'b1;
        cyc(2);
        expectOut("layer0_wins", 12'hF00, 1'b1);
        vif.pLayerOpaque = 4'b0100;
        cyc(2);
        expectOut("layer2_only", 12'h0F0, 1'b1);

        // Background, then blanking
        vif.pLayerOpaque = 4'b0000;
        vif.pBackground  = 12'h123;
        cyc(2);
        expectOut("background", 12'h123, 1'b1);
        vif.pVideo_on = 1'b0;
        cyc(2);
        expectOut("blanked", 12'h000, 1'b0);

        // Full fade-out of a white pixel
        vif.pVideo_on    = 1'b1;
        vif.pLayerPix    = {12'h000, 12'h0F0, 12'h000, 12'hFFF};
        vif.pLayerOpaque = 4'b0001;
        cyc(2);
        expectOut("white_full", 12'hFFF, 1'b1);
        go(2'b10, 1'b0);
        expectFade("fo_start", 16, 1'b1);
        for (int i = 0; i < 16; i++) begin
            step();
            expectFade("fo_step", 15 - i, i != 15);
            if (i == 7) begin
                cyc(1);
                expectOut("white_lvl8", 12'h777, 1'b1);
            end
        end
        cyc(1);
        expectOut("white_lvl0", 12'h000, 1'b1);

        // Fade-out at 0 saturates
        go(2'b10, 1'b0);
        expectFade("fo_at0", 0, 1'b1);
        step();
        expectFade("fo_at0_done", 0, 1'b0);

        // Snap, then fade-in at max saturates
        go(2'b11, 1'b0);
        expectFade("snap_from0", 16, 1'b0);
        go(2'b01, 1'b0);
        expectFade("fi_atmax", 16, 1'b1);
        step();
        expectFade("fi_atmax_done", 16, 1'b0);

        // Reverse mid-fade with coincident frame tick
        go(2'b10, 1'b0);
        repeat (11) step();
        expectFade("fo_to5", 5, 1'b1);
        go(2'b01, 1'b1);
        expectFade("reverse_same", 5, 1'b1);
        step();
        expectFade("reverse_step", 6, 1'b1);

        // Snap from level 3
        go(2'b10, 1'b0);
        repeat (3) step();
        expectFade("fo_to3", 3, 1'b1);
        go(2'b11, 1'b0);
        expectFade("snap_from3", 16, 1'b0);

        // Hold, then frame tick in idle
        go(2'b10, 1'b0);
        step();
        go(2'b00, 1'b0);
        expectFade("hold", 15, 1'b0);
        step();
        expectFade("idle_tick", 15, 1'b0);

        // Reset mid-fade
        go(2'b10, 1'b0);
        repeat (8) step();
        expectFade("fo_to7", 7, 1'b1);
        pReset = 1'b1;
        cyc(1);
        expectFade("midfade_reset", 16, 1'b0);
        expectOut("midfade_reset_out", 12'h000, 1'b0);
        pReset = 1'b0;
        cyc(1);
        expectOut("post_reset_1", 12'h000, 1'b0);
        cyc(1);
        expectOut("post_reset_2", 12'hFFF, 1'b1);

        cyc(2);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

endmodule
